afifo72_tx_drain: RTL and testbench
===================================

AFIFO72_TX_DRAIN -- requirements
Module: afifo72_tx_drain

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 2, idle cycles forced after each tlast (0 = back-to-back frames).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of the statistics counters.
REQ-003 SHALL have ports:
- rd_clk, input, 1: sole clock (FIFO read side, 156.25 MHz).
- rst_n, input, 1: asynchronous, active-low reset.
- fifo_dout, input, 72: FIFO read data.
- fifo_empty, input, 1: FIFO empty.
- fifo_rd_en, output, 1: FIFO read strobe.
- tx_tdata, output, 64: stream data.
- tx_tkeep, output, 8: byte enables.
- tx_tlast, output, 1: last word of the frame.
- tx_tvalid, output, 1: word valid.
- tx_tready, input, 1: downstream accept.
- frame_cnt, output, CNT_WIDTH: frames sent.
- underrun_cnt, output, CNT_WIDTH: frames with a mid-frame underrun.

Function
REQ-004 SHALL decode each FIFO word as follows:
- [63:0] data.
- [71] eof.
- [66:64] valid bytes minus 1 on an eof word.
- [70:67] ignored.
REQ-005 SHALL set tkeep to 8'hFF on non-eof words.
REQ-006 SHALL set tkeep on eof words to (2^(n+1))-1, where n = [66:64] (n=0 -> 8'h01, n=7 -> 8'hFF); tlast = eof.
REQ-007 SHALL treat the FIFO as having 1-cycle read latency: fifo_dout is valid in the cycle after a cycle with fifo_rd_en=1.
REQ-008 SHALL assert fifo_rd_en only when fifo_empty=0 and (buffered words + in-flight read) < 2, after counting a same-cycle output handshake as freeing a slot.
REQ-009 SHALL hold returned words in a 2-entry in-order output buffer; no word is ever dropped or duplicated.
REQ-010 SHALL sustain 1 word/cycle with tready held at 1 and the FIFO non-empty.
REQ-011 SHALL keep tdata/tkeep/tlast stable while tvalid=1 and tready=0.
REQ-012 SHALL implement a 2-state FSM, XFER and GAP.
REQ-013 In XFER, tvalid SHALL equal buffer non-empty.
REQ-014 A handshake with tlast=1 in XFER SHALL:
- increment frame_cnt;
- go to GAP with the gap counter loaded to IFG_CYCLES if IFG_CYCLES>0;
- otherwise remain in XFER.
REQ-015 In GAP, tvalid SHALL be 0 and the gap counter SHALL decrement each cycle; on the cycle it reads 1, the FSM SHALL return to XFER.
REQ-016 FIFO reads SHALL continue during GAP (prefetch), subject to REQ-008.
REQ-017 SHALL track an in_frame flag:
- set on a handshake with tlast=0;
- cleared on a handshake with tlast=1.
REQ-018 underrun_cnt SHALL increment at most once per frame, on the first cycle with in_frame=1, state XFER, buffer empty, and no read in flight.
REQ-019 Counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-020 A tlast handshake and an underrun condition in the same cycle SHALL NOT count an underrun, since the buffer is non-empty.

Reset
REQ-021 While rst_n=0, the block SHALL drive:
- fifo_rd_en=0, tx_tvalid=0;
- tx_tdata=0, tx_tkeep=0, tx_tlast=0;
- frame_cnt=0, underrun_cnt=0.
REQ-022 While rst_n=0, the block SHALL also clear the buffer, in-flight flag, in_frame and gap counter, with the FSM in XFER.
REQ-023 Reset asserted mid-frame SHALL discard buffered and in-flight words.
REQ-024 After reset release, the first fifo_rd_en SHALL be no earlier than the first rising edge with rst_n=1.

Verification
REQ-025 Write 3-word frame (eof on word 3, n=2), tready=1 -> tvalid for 3 consecutive cycles, tkeep FF,FF,07, tlast on word 3, frame_cnt=1.
REQ-026 Two back-to-back 2-word frames, IFG_CYCLES=2, tready=1 -> exactly 2 cycles of tvalid=0 between frames, frame_cnt=2.
REQ-027 Continuous stream with tready toggling 1,0,0,1,... -> output sequence equals input sequence, no loss/duplication, fifo_rd_en never raises occupancy above 2, data stable while stalled.
REQ-028 Frame word 1 sent, FIFO empty for 5 cycles, then words 2-3 written -> underrun_cnt=1 (not 5), frame completes, frame_cnt=1.
REQ-029 rst_n pulsed low mid-frame with 2 words buffered -> outputs zero immediately (async), and after release the next FIFO word is the first output word.
REQ-030 IFG_CYCLES=0, single-word frames (n=7) continuous -> tvalid=1 every cycle, tkeep=FF, tlast=1 every word.

Source files
------------

// File: rtl/afifo72_tx_drain.sv
// Drains a 72-bit FIFO (1-cycle read latency) into a 64-bit AXI-Stream with
// per-frame inter-frame gap insertion and frame/underrun statistics.
module afifo72_tx_drain #(
    parameter int IFG_CYCLES = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    input  logic [71:0]          fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [63:0]          tx_tdata,
    output logic [7:0]           tx_tkeep,
    output logic                 tx_tlast,
    output logic                 tx_tvalid,
    input  logic                 tx_tready,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] underrun_cnt
);

    // state | meaning
    // XFER  | tvalid follows buffer occupancy
    // GAP   | tvalid held low for IFG_CYCLES after a tlast handshake
    typedef enum logic {XFER = 1'b0, GAP = 1'b1} state_t;

    localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    state_t          state, state_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;

    logic [67:0]     buf0, buf1, head;
    logic            rd_ptr, wr_ptr;
    logic [1:0]      count;
    logic            inflight;
    logic            run;
    logic            in_frame;
    logic            ur_seen;
    logic            head_vld;
    logic            pop;
    logic            push;
    logic [2:0]      occ_after;
    logic [8:0]      keep_wide;
    logic            ur_cond;
    logic            unused_bits;

    assign unused_bits = ^fifo_dout[70:67];

    assign head      = rd_ptr ? buf1 : buf0;
    assign head_vld  = (count != 2'd0);
    assign keep_wide = (9'd2 << head[66:64]) - 9'd1;

    assign tx_tdata = head_vld ? head[63:0] : 64'd0;
    assign tx_tlast = head_vld & head[67];
    assign tx_tkeep = !head_vld ? 8'h00 : (head[67] ? keep_wide[7:0] : 8'hFF);

    assign pop  = tx_tvalid & tx_tready;
    assign push = inflight;

    // Occupancy seen by the next read: a same-cycle pop frees its slot.
    assign occ_after  = {1'b0, count} + 3'(inflight) - 3'(pop);
    assign fifo_rd_en = run & ~fifo_empty & (occ_after < 3'd2);

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0     <= '0;
            buf1     <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            inflight <= 1'b0;
            run      <= 1'b0;
        end else begin
            if (push) begin
                if (wr_ptr) buf1 <= {fifo_dout[71], fifo_dout[66:64], fifo_dout[63:0]};
                else        buf0 <= {fifo_dout[71], fifo_dout[66:64], fifo_dout[63:0]};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count    <= count + 2'(push) - 2'(pop);
            inflight <= fifo_rd_en;
            run      <= 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= XFER;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        tx_tvalid = 1'b0;
        case (state)
            XFER: begin
                tx_tvalid = head_vld;
                if (head_vld && tx_tready && tx_tlast && (IFG_CYCLES > 0)) begin
                    state_nxt = GAP;
                    gap_nxt   = GW'(IFG_CYCLES);
                end
            end
            GAP: begin
                gap_nxt = gap_cnt - GW'(1);
                if (gap_cnt == GW'(1)) state_nxt = XFER;
            end
            default: state_nxt = XFER;
        endcase
    end

    // One underrun per frame: ur_seen latches until the frame's tlast.
    assign ur_cond = in_frame & (state == XFER) & ~head_vld & ~inflight;

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt    <= '0;
            underrun_cnt <= '0;
            in_frame     <= 1'b0;
            ur_seen      <= 1'b0;
        end else begin
            if (pop) begin
                in_frame <= ~tx_tlast;
                if (tx_tlast) begin
                    frame_cnt <= frame_cnt + CNT_WIDTH'(1);
                    ur_seen   <= 1'b0;
                end
            end
            if (ur_cond && !ur_seen) begin
                underrun_cnt <= underrun_cnt + CNT_WIDTH'(1);
                ur_seen      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_afifo72_tx_drain.sv
// Directed bench for afifo72_tx_drain: main instance with IFG_CYCLES=2,
// second instance with IFG_CYCLES=0 for back-to-back single-word frames.
`timescale 1ns/1ps
module tb_afifo72_tx_drain;

    logic        rd_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [71:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic        tx_tlast, tx_tvalid;
    logic        tx_tready = 1'b1;
    logic [31:0] frame_cnt, underrun_cnt;

    logic [71:0] fifo_dout1 = '0;
    logic        fifo_empty1 = 1'b1;
    logic        fifo_rd_en1;
    logic [63:0] tx_tdata1;
    logic [7:0]  tx_tkeep1;
    logic        tx_tlast1, tx_tvalid1;
    logic        tx_tready1 = 1'b1;
    logic [31:0] frame_cnt1, underrun_cnt1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } hs_t;

    hs_t         obs[$];
    logic [71:0] fq[$], pend[$], fq1[$], pend1[$];

    afifo72_tx_drain #(.IFG_CYCLES(2), .CNT_WIDTH(32)) u_dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .frame_cnt(frame_cnt),
        .underrun_cnt(underrun_cnt)
    );

    afifo72_tx_drain #(.IFG_CYCLES(0), .CNT_WIDTH(32)) u_dut0 (
        .rd_clk(rd_clk), .rst_n(rst_n), .fifo_dout(fifo_dout1), .fifo_empty(fifo_empty1),
        .fifo_rd_en(fifo_rd_en1), .tx_tdata(tx_tdata1), .tx_tkeep(tx_tkeep1), .tx_tlast(tx_tlast1),
        .tx_tvalid(tx_tvalid1), .tx_tready(tx_tready1), .frame_cnt(frame_cnt1),
        .underrun_cnt(underrun_cnt1)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string tag, input logic [95:0] o, input logic [95:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [71:0] mkw(input logic eof, input logic [2:0] n, input logic [63:0] d);
        return {eof, 4'b0000, n, d};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [71:0] w);
        pend.push_back(w);
    endtask

    task automatic expect_word(input string tag, input logic last, input logic [7:0] keep,
                               input logic [63:0] data, output int c);
        hs_t e;
        chk({tag, "_present"}, 96'(obs.size() > 0), 96'd1);
        c = -1;
        if (obs.size() > 0) begin
            e = obs.pop_front();
            chk(tag, 96'({e.last, e.keep, e.data}), 96'({last, keep, data}));
            c = e.cyc;
        end
    endtask

    // FIFO models: 1-cycle read latency; words written by the stimulus land at the next edge.
    always @(posedge rd_clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            chk("rd_on_empty", 96'(fq.size() != 0), 96'd1);
            if (fq.size() != 0) fifo_dout <= fq.pop_front();
        end
        while (pend.size() != 0) fq.push_back(pend.pop_front());
        fifo_empty <= (fq.size() == 0);
    end

    always @(posedge rd_clk) begin
        if (fifo_rd_en1 && fq1.size() != 0) fifo_dout1 <= fq1.pop_front();
        while (pend1.size() != 0) fq1.push_back(pend1.pop_front());
        fifo_empty1 <= (fq1.size() == 0);
    end

    // Output monitor: records handshakes, checks occupancy bound and stall stability.
    int          rd_tot = 0, hs_tot = 0;
    logic        stall_prev = 1'b0;
    logic [72:0] prev_word = '0;
    always @(negedge rd_clk) begin
        if (!rst_n) begin
            rd_tot = 0;
            hs_tot = 0;
            stall_prev = 1'b0;
        end else begin
            chk("occupancy", 96'((rd_tot - hs_tot - int'(tx_tvalid && tx_tready) + int'(fifo_rd_en)) <= 2), 96'd1);
            if (stall_prev)
                chk("stall_stable", 96'({tx_tvalid, tx_tlast, tx_tkeep, tx_tdata}), 96'({1'b1, prev_word}));
            if (tx_tvalid && tx_tready) begin
                obs.push_back('{cyc: cyc, last: tx_tlast, keep: tx_tkeep, data: tx_tdata});
                hs_tot++;
            end
            if (fifo_rd_en) rd_tot++;
            stall_prev = tx_tvalid && !tx_tready;
            prev_word  = {tx_tlast, tx_tkeep, tx_tdata};
        end
    end

    initial begin
        int c0, c1, c2, c3;
        logic found;

        // Reset with a word already waiting in the FIFO
        step(2);
        push(mkw(1'b1, 3'd1, 64'hA0));
        step(1);
        chk("rst_rd_en", 96'(fifo_rd_en), 96'd0);
        chk("rst_tvalid", 96'(tx_tvalid), 96'd0);
        chk("rst_tdata", 96'(tx_tdata), 96'd0);
        chk("rst_tkeep", 96'(tx_tkeep), 96'd0);
        chk("rst_tlast", 96'(tx_tlast), 96'd0);
        chk("rst_frame_cnt", 96'(frame_cnt), 96'd0);
        chk("rst_underrun_cnt", 96'(underrun_cnt), 96'd0);
        @(negedge rd_clk);
        rst_n = 1'b1;
        #1;
        chk("rd_before_first_edge", 96'(fifo_rd_en), 96'd0);
        @(posedge rd_clk);
        #1;
        chk("rd_after_first_edge", 96'(fifo_rd_en), 96'd1);
        step(5);
        expect_word("init_word", 1'b1, 8'h03, 64'hA0, c0);
        chk("init_frame_cnt", 96'(frame_cnt), 96'd1);

        // 3-word frame, n=2 on the eof word
        push(mkw(1'b0, 3'd0, 64'hA1));
        push(mkw(1'b0, 3'd0, 64'hA2));
        push(mkw(1'b1, 3'd2, 64'hA3));
        step(10);
        expect_word("a_w0", 1'b0, 8'hFF, 64'hA1, c0);
        expect_word("a_w1", 1'b0, 8'hFF, 64'hA2, c1);
        expect_word("a_w2", 1'b1, 8'h07, 64'hA3, c2);
        chk("a_consecutive", 96'({c1 - c0, c2 - c0}), 96'({32'd1, 32'd2}));
        chk("a_frame_cnt", 96'(frame_cnt), 96'd2);

        // Two back-to-back 2-word frames: exactly two idle cycles between them
        push(mkw(1'b0, 3'd0, 64'hB0));
        push(mkw(1'b1, 3'd7, 64'hB1));
        push(mkw(1'b0, 3'd0, 64'hB2));
        push(mkw(1'b1, 3'd0, 64'hB3));
        step(14);
        expect_word("b_w0", 1'b0, 8'hFF, 64'hB0, c0);
        expect_word("b_w1", 1'b1, 8'hFF, 64'hB1, c1);
        expect_word("b_w2", 1'b0, 8'hFF, 64'hB2, c2);
        expect_word("b_w3", 1'b1, 8'h01, 64'hB3, c3);
        chk("b_spacing", 96'({c1 - c0, c2 - c1, c3 - c2}), 96'({32'd1, 32'd3, 32'd1}));
        chk("b_frame_cnt", 96'(frame_cnt), 96'd4);

        // Stream under tready pattern 1,0,0,1
        for (int i = 0; i < 12; i++)
            push(mkw(i == 5 || i == 11, (i == 5) ? 3'd3 : 3'd6, 64'hC00 + 64'(i)));
        for (int i = 0; i < 60; i++) begin
            tx_tready = ((i % 4) == 0) || ((i % 4) == 3);
            step(1);
        end
        tx_tready = 1'b1;
        step(10);
        chk("c_count", 96'(obs.size()), 96'd12);
        for (int i = 0; i < 12; i++)
            expect_word("c_word", i == 5 || i == 11,
                        (i == 5) ? 8'h0F : ((i == 11) ? 8'h7F : 8'hFF), 64'hC00 + 64'(i), c0);
        chk("c_frame_cnt", 96'(frame_cnt), 96'd6);
        chk("c_underrun_cnt", 96'(underrun_cnt), 96'd0);

        // Mid-frame starvation counts one underrun
        push(mkw(1'b0, 3'd0, 64'hD0));
        step(8);
        chk("d_underrun_once", 96'(underrun_cnt), 96'd1);
        expect_word("d_w0", 1'b0, 8'hFF, 64'hD0, c0);
        push(mkw(1'b0, 3'd0, 64'hD1));
        push(mkw(1'b1, 3'd5, 64'hD2));
        step(8);
        expect_word("d_w1", 1'b0, 8'hFF, 64'hD1, c1);
        expect_word("d_w2", 1'b1, 8'h3F, 64'hD2, c2);
        chk("d_underrun_final", 96'(underrun_cnt), 96'd1);
        chk("d_frame_cnt", 96'(frame_cnt), 96'd7);

        // Reset mid-frame with two words buffered
        tx_tready = 1'b0;
        push(mkw(1'b0, 3'd0, 64'hE0));
        push(mkw(1'b0, 3'd0, 64'hE1));
        push(mkw(1'b0, 3'd0, 64'hE2));
        push(mkw(1'b1, 3'd4, 64'hE3));
        step(5);
        chk("e_head0", 96'({tx_tvalid, tx_tdata}), 96'({1'b1, 64'hE0}));
        tx_tready = 1'b1;
        step(1);
        tx_tready = 1'b0;
        step(3);
        chk("e_head1", 96'({tx_tvalid, tx_tdata}), 96'({1'b1, 64'hE1}));
        #3;
        rst_n = 1'b0;
        #1;
        chk("e_rst_stream", 96'({fifo_rd_en, tx_tvalid, tx_tlast, tx_tkeep, tx_tdata}), 96'd0);
        chk("e_rst_counters", 96'({frame_cnt, underrun_cnt}), 96'd0);
        step(2);
        rst_n = 1'b1;
        tx_tready = 1'b1;
        step(8);
        expect_word("e_pre_reset", 1'b0, 8'hFF, 64'hE0, c0);
        expect_word("e_after_reset", 1'b1, 8'h1F, 64'hE3, c1);
        chk("e_leftover", 96'(obs.size()), 96'd0);
        chk("e_frame_cnt", 96'(frame_cnt), 96'd1);
        chk("e_underrun_cnt", 96'(underrun_cnt), 96'd0);

        // IFG_CYCLES=0: single-word frames every cycle
        for (int i = 0; i < 10; i++)
            pend1.push_back(mkw(1'b1, 3'd7, 64'hF0 + 64'(i)));
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge rd_clk);
            found = tx_tvalid1;
        end
        chk("f_start", 96'(found), 96'd1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge rd_clk);
            chk("f_word", 96'({tx_tvalid1, tx_tlast1, tx_tkeep1, tx_tdata1}),
                96'({1'b1, 1'b1, 8'hFF, 64'hF0 + 64'(i)}));
        end
        step(3);
        chk("f_frame_cnt", 96'(frame_cnt1), 96'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
